// File: rtl/cdb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cdb_arbiter_pkg
//   Shared write-back types for the execute -> ROB / PRF / wakeup path, plus
//   the constants used by the CDB arbiter.
//   CDB_t    : broadcast record (valid, dest, flags, result)
//   rob_wb_t : ROB write-back (rob_dest, cdb)
//   reg_wb_t : register-file write-back (cdb, w_v)
// ----------------------------------------------------------------------------
package cdb_arbiter_pkg;

   localparam int ROB_ENTRY     = 16;
   localparam int CDB_ROB_IDX_W = $clog2(ROB_ENTRY);
   localparam int PREG_W        = 6;
   localparam int XLEN          = 32;

   // Arbiter configuration
   localparam int CDB_ARB_CNT_W   = 16;
   localparam int CDB_ARB_NUM_REQ = 3;

   typedef struct packed {
      logic              valid;
      logic [PREG_W-1:0] dest;
      logic [1:0]        flags;
      logic [XLEN-1:0]   result;
   } CDB_t;

   typedef struct packed {
      logic [CDB_ROB_IDX_W-1:0] rob_dest;
      CDB_t                     cdb;
   } rob_wb_t;

   typedef struct packed {
      CDB_t cdb;
      logic w_v;
   } reg_wb_t;

   localparam int CDB_WIDTH    = $bits(CDB_t);
   localparam int ROB_WB_WIDTH = $bits(rob_wb_t);
   localparam int REG_WB_WIDTH = $bits(reg_wb_t);

endpackage

// File: rtl/cdb_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. Grants the first requester at or
//   above ptr_i, wrapping to index 0.
//   req_i     : request vector
//   ptr_i     : highest-priority index this cycle
//   gnt_o     : one-hot grant (all zero when no request)
//   gnt_idx_o : binary index of the grant (valid when gnt_v_o)
//   gnt_v_o   : any grant issued
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0]   gnt_idx_o,
   output logic               gnt_v_o
);

   // Two constant-index passes: indices >= ptr first, then the wrapped ones
   // below ptr. Avoids a variable-width modulo on the index.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_v_o   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_v_o && req_i[i] && (PTR_W'(i) >= ptr_i)) begin
            gnt_v_o   = 1'b1;
            gnt_o[i]  = 1'b1;
            gnt_idx_o = PTR_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_v_o && req_i[i] && (PTR_W'(i) < ptr_i)) begin
            gnt_v_o   = 1'b1;
            gnt_o[i]  = 1'b1;
            gnt_idx_o = PTR_W'(i);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter
//   Round-robin arbitration of NUM_REQ execution-unit results onto the single
//   CDB / ROB write-back port. One grant per cycle, outputs registered
//   (1-cycle latency, valid for exactly one cycle).
//   clk_i, reset_n_i : clock, async active-low reset
//   flush_i          : suppress this cycle's grant
//   req_v_i/req_w_v_i: per-unit valid / writes-a-register flag
//   req_cdb_i        : per-unit packed CDB_t (valid field ignored)
//   req_rob_i        : per-unit ROB index
//   req_ready_o      : one-hot combinational grant
//   cdb_o/rob_wb_o/reg_wb_o : registered broadcast records
//   Optional (macro CDB_ARB_STATS_EN): stall_cnt_o, per-unit saturating
//   16-bit count of cycles spent valid but not granted.
// ----------------------------------------------------------------------------
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = CDB_ARB_NUM_REQ,
   parameter int ROB_IDX_W = $clog2(ROB_ENTRY)
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           flush_i,
   input  logic [NUM_REQ-1:0]             req_v_i,
   input  logic [NUM_REQ-1:0]             req_w_v_i,
   input  logic [NUM_REQ*CDB_WIDTH-1:0]   req_cdb_i,
   input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic [CDB_WIDTH-1:0]           cdb_o,
   output logic [ROB_WB_WIDTH-1:0]        rob_wb_o,
   output logic [REG_WB_WIDTH-1:0]        reg_wb_o
`ifdef CDB_ARB_STATS_EN
  ,output logic [NUM_REQ*CDB_ARB_CNT_W-1:0] stall_cnt_o
`endif
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0] arb_gnt, gnt;
   logic [PTR_W-1:0]   gnt_idx;
   logic               arb_v, gnt_v;

   CDB_t               req_cdb [NUM_REQ];
   logic [ROB_IDX_W-1:0] req_rob [NUM_REQ];

   CDB_t    cdb_q, cdb_d, sel_cdb;
   rob_wb_t rob_wb_q, rob_wb_d;
   reg_wb_t reg_wb_q, reg_wb_d;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_cdb[g] = req_cdb_i[g*CDB_WIDTH +: CDB_WIDTH];
      assign req_rob[g] = req_rob_i[g*ROB_IDX_W +: ROB_IDX_W];
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
      .req_i     (req_v_i),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (arb_gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_v_o   (arb_v)
   );

   // No handshake while flushing or while reset is held, so units never see
   // a transfer that the registers will not capture.
   assign gnt_v       = arb_v & ~flush_i & reset_n_i;
   assign gnt         = gnt_v ? arb_gnt : '0;
   assign req_ready_o = gnt;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_v)
         rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
   end

   // Data fields hold their last value on idle cycles; only the valid bits
   // are forced low.
   always_comb begin
      sel_cdb       = req_cdb[gnt_idx];
      sel_cdb.valid = 1'b1;

      cdb_d              = cdb_q;
      rob_wb_d           = rob_wb_q;
      reg_wb_d           = reg_wb_q;
      cdb_d.valid        = 1'b0;
      rob_wb_d.cdb.valid = 1'b0;
      reg_wb_d.cdb.valid = 1'b0;
      reg_wb_d.w_v       = 1'b0;

      if (gnt_v) begin
         rob_wb_d.rob_dest = CDB_ROB_IDX_W'(req_rob[gnt_idx]);
         rob_wb_d.cdb      = sel_cdb;
         reg_wb_d.cdb      = sel_cdb;
         reg_wb_d.w_v      = req_w_v_i[gnt_idx];
         cdb_d             = sel_cdb;
         cdb_d.valid       = req_w_v_i[gnt_idx];
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rr_ptr_q <= '0;
         cdb_q    <= '0;
         rob_wb_q <= '0;
         reg_wb_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         cdb_q    <= cdb_d;
         rob_wb_q <= rob_wb_d;
         reg_wb_q <= reg_wb_d;
      end
   end

   assign cdb_o    = cdb_q;
   assign rob_wb_o = rob_wb_q;
   assign reg_wb_o = reg_wb_q;

`ifdef CDB_ARB_STATS_EN
   logic [NUM_REQ-1:0][CDB_ARB_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Flush still counts as a stall: the unit was valid and not accepted.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_v_i[i] && !gnt[i] && (stall_cnt_q[i] != '1))
            stall_cnt_d[i] = stall_cnt_q[i] + CDB_ARB_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) stall_cnt_q <= '0;
      else            stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   // Stall statistics not built.
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N  = 3;
   localparam int RW = CDB_ROB_IDX_W;

   logic clk = 1'b0;
   logic rst_n, flush;
   logic [N-1:0] req_v, req_w_v, req_ready;
   logic [N*CDB_WIDTH-1:0] req_cdb;
   logic [N*RW-1:0]        req_rob;
   logic [CDB_WIDTH-1:0]    cdb_o;
   logic [ROB_WB_WIDTH-1:0] rob_wb_o;
   logic [REG_WB_WIDTH-1:0] reg_wb_o;
`ifdef CDB_ARB_STATS_EN
   logic [N*CDB_ARB_CNT_W-1:0] stall_cnt;
`endif

   CDB_t          u_cdb [N];
   logic [RW-1:0] u_rob [N];

   CDB_t    o_cdb;
   rob_wb_t o_rob;
   reg_wb_t o_reg;
   assign o_cdb = cdb_o;
   assign o_rob = rob_wb_o;
   assign o_reg = reg_wb_o;

   always_comb begin
      req_cdb = '0;
      req_rob = '0;
      for (int i = 0; i < N; i++) begin
         req_cdb[i*CDB_WIDTH +: CDB_WIDTH] = u_cdb[i];
         req_rob[i*RW +: RW]               = u_rob[i];
      end
   end

   cdb_arbiter #(.NUM_REQ(N), .ROB_IDX_W(RW)) dut (
      .clk_i       (clk),
      .reset_n_i   (rst_n),
      .flush_i     (flush),
      .req_v_i     (req_v),
      .req_w_v_i   (req_w_v),
      .req_cdb_i   (req_cdb),
      .req_rob_i   (req_rob),
      .req_ready_o (req_ready),
      .cdb_o       (cdb_o),
      .rob_wb_o    (rob_wb_o),
      .reg_wb_o    (reg_wb_o)
`ifdef CDB_ARB_STATS_EN
     ,.stall_cnt_o (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic              v;
      logic              w_v;
      logic [RW-1:0]     rob;
      logic [PREG_W-1:0] dest;
      logic [1:0]        flags;
      logic [XLEN-1:0]   res;
   } exp_t;

   exp_t exp_q[$];
   exp_t m_e;

   task automatic set_unit(input int i, input logic [RW-1:0] rob, input logic [PREG_W-1:0] dest,
                           input logic [1:0] flags, input logic [XLEN-1:0] res, input logic w);
      u_cdb[i].valid  = 1'b0;   // ignored by the DUT
      u_cdb[i].dest   = dest;
      u_cdb[i].flags  = flags;
      u_cdb[i].result = res;
      u_rob[i]        = rob;
      req_w_v[i]      = w;
   endtask

   // Expected output record for the grant just driven (g < 0: idle).
   task automatic push_exp(input int g);
      exp_t e;
      e = '{v: 1'b0, w_v: 1'b0, rob: '0, dest: '0, flags: '0, res: '0};
      if (g >= 0) begin
         e.v     = 1'b1;
         e.w_v   = req_w_v[g];
         e.rob   = u_rob[g];
         e.dest  = u_cdb[g].dest;
         e.flags = u_cdb[g].flags;
         e.res   = u_cdb[g].result;
      end
      exp_q.push_back(e);
   endtask

   // Scoreboard: each record pushed in cycle N is compared in cycle N+1.
   always @(negedge clk) begin
      if (rst_n && exp_q.size() > 0) begin
         m_e = exp_q.pop_front();
         n_tests++;
         if ({o_rob.cdb.valid, o_reg.cdb.valid, o_cdb.valid, o_reg.w_v} !==
             {m_e.v, m_e.v, m_e.v & m_e.w_v, m_e.v & m_e.w_v}) begin
            n_fail++;
            $display("FAIL out_valids: got %b want %b", {o_rob.cdb.valid, o_reg.cdb.valid, o_cdb.valid, o_reg.w_v},
                     {m_e.v, m_e.v, m_e.v & m_e.w_v, m_e.v & m_e.w_v});
         end
         if (m_e.v) begin
            n_tests++;
            if (o_rob.rob_dest !== m_e.rob || o_rob.cdb !== {1'b1, m_e.dest, m_e.flags, m_e.res}) begin
               n_fail++;
               $display("FAIL rob_wb: got %h want %h", rob_wb_o, {m_e.rob, 1'b1, m_e.dest, m_e.flags, m_e.res});
            end
            n_tests++;
            if (o_reg.cdb !== {1'b1, m_e.dest, m_e.flags, m_e.res} ||
                {o_cdb.dest, o_cdb.flags, o_cdb.result} !== {m_e.dest, m_e.flags, m_e.res}) begin
               n_fail++;
               $display("FAIL cdb_reg_payload: got cdb %h reg %h want %h", cdb_o, reg_wb_o,
                        {m_e.dest, m_e.flags, m_e.res});
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      req_v = '0;
      flush = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      for (int i = 0; i < N; i++) set_unit(i, RW'(i), PREG_W'(i + 1), 2'(i), XLEN'(32'h100 + i), 1'b1);
      req_v = 3'b111;
      @(negedge clk); #1;
      n_tests++;
      if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b want 000", req_ready); end
      n_tests++;
      if ({cdb_o, rob_wb_o, reg_wb_o} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h %h %h want 0", cdb_o, rob_wb_o, reg_wb_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_tests++;
      if (req_ready !== 3'b001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 001", req_ready); end
      push_exp(0);
      @(negedge clk);
      req_v = '0;
      #1 push_exp(-1);
   endtask

   task automatic test_single();
      @(negedge clk);
      set_unit(1, 4'd5, 6'd12, 2'b10, 32'h0000_00A5, 1'b1);
      req_v = 3'b010;
      #1;
      n_tests++;
      if (req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready: got %b want 010", req_ready); end
      push_exp(1);
      @(negedge clk);
      req_v = '0;
      #1;
      n_tests++;
      if (req_ready !== 3'b000) begin n_fail++; $display("FAIL idle_ready: got %b want 000", req_ready); end
      push_exp(-1);
   endtask

   task automatic test_contention();
      int order [6] = '{0, 1, 2, 0, 1, 2};
      int prev_g = -1;
      do_reset();
      for (int i = 0; i < N; i++) set_unit(i, RW'(i + 1), PREG_W'(8 + i), 2'(i), XLEN'(32'hC000_0000 + i), 1'b1);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (prev_g >= 0)
            set_unit(prev_g, RW'(c * 3 + prev_g), PREG_W'(20 + c), 2'(c), XLEN'(32'hD000_0000 + c), 1'b1);
         req_v = 3'b111;
         #1;
         n_tests++;
         if (req_ready !== 3'(1 << order[c])) begin
            n_fail++; $display("FAIL contention_ready[%0d]: got %b want %b", c, req_ready, 3'(1 << order[c]));
         end
         push_exp(order[c]);
         prev_g = order[c];
      end
      @(negedge clk);
      req_v = '0;
      #1 push_exp(-1);
   endtask

   task automatic test_no_wb();
      @(negedge clk);
      set_unit(2, 4'd9, 6'd33, 2'b11, 32'h0005_707E, 1'b0);
      req_v = 3'b100;
      #1;
      n_tests++;
      if (req_ready !== 3'b100) begin n_fail++; $display("FAIL nowb_ready: got %b want 100", req_ready); end
      push_exp(2);
      @(negedge clk);
      req_v = '0;
      #1 push_exp(-1);
   endtask

   // Entered with the pointer at 0 (last grant went to unit 2).
   task automatic test_flush();
      @(negedge clk);
      set_unit(0, 4'd3, 6'd40, 2'b01, 32'hF1F1_0000, 1'b1);
      set_unit(2, 4'd4, 6'd41, 2'b10, 32'hF1F1_0002, 1'b1);
      req_v = 3'b101;
      flush = 1'b1;
      for (int c = 0; c < 2; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         n_tests++;
         if (req_ready !== 3'b000) begin n_fail++; $display("FAIL flush_ready[%0d]: got %b want 000", c, req_ready); end
         push_exp(-1);
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 3'b001) begin n_fail++; $display("FAIL post_flush_ready: got %b want 001", req_ready); end
      push_exp(0);
      @(negedge clk);
      set_unit(0, 4'd6, 6'd42, 2'b00, 32'hF1F1_0010, 1'b1);
      #1;
      n_tests++;
      if (req_ready !== 3'b100) begin n_fail++; $display("FAIL post_flush_next: got %b want 100", req_ready); end
      push_exp(2);
      @(negedge clk);
      req_v = '0;
      #1 push_exp(-1);
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      set_unit(1, 4'd7, 6'd50, 2'b01, 32'hAB00_0001, 1'b1);
      req_v = 3'b010;
      #1;
      n_tests++;
      if (req_ready !== 3'b010) begin n_fail++; $display("FAIL mid_ready: got %b want 010", req_ready); end
      @(posedge clk); #2;
      req_v = '0;
      n_tests++;
      if (o_rob.cdb.valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", o_rob.cdb.valid); end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({cdb_o, rob_wb_o, reg_wb_o} !== '0) begin
         n_fail++; $display("FAIL mid_async_clear: got %h %h %h want 0", cdb_o, rob_wb_o, reg_wb_o);
      end
      @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) set_unit(i, RW'(10 + i), PREG_W'(60 + i), 2'(i), XLEN'(32'hBE00_0000 + i), 1'b1);
      req_v = 3'b111;
      #1;
      n_tests++;
      if (req_ready !== 3'b001) begin n_fail++; $display("FAIL mid_first_grant: got %b want 001", req_ready); end
      push_exp(0);
      @(negedge clk);
      req_v = '0;
      #1 push_exp(-1);
   endtask

   // Random traffic obeying the hold-until-granted rule; checks grant choice
   // against a round-robin model and the NUM_REQ-cycle fairness bound.
   task automatic test_back_to_back();
      int m_ptr = 0;
      int last_g = -1;
      int waitc [N];
      do_reset();
      for (int i = 0; i < N; i++) waitc[i] = 0;
      for (int c = 0; c < 60; c++) begin
         int g;
         @(negedge clk);
         if (last_g >= 0) req_v[last_g] = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!req_v[i] && $urandom_range(0, 3) != 0) begin
               set_unit(i, RW'($urandom), PREG_W'($urandom), 2'($urandom), $urandom, 1'($urandom));
               req_v[i] = 1'b1;
            end
         end
         g = -1;
         for (int k = 0; k < N; k++) begin
            if (g < 0 && req_v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
         #1;
         n_tests++;
         if (req_ready !== ((g >= 0) ? 3'(1 << g) : 3'b000)) begin
            n_fail++; $display("FAIL rand_ready[%0d]: got %b want grant idx %0d", c, req_ready, g);
         end
         push_exp(g);
         for (int i = 0; i < N; i++) if (req_v[i] && i != g) waitc[i]++;
         if (g >= 0) begin
            n_tests++;
            if (waitc[g] > N - 1) begin n_fail++; $display("FAIL fairness: unit %0d waited %0d want <= %0d", g, waitc[g], N - 1); end
            waitc[g] = 0;
            m_ptr = (g + 1) % N;
         end
         last_g = g;
      end
      @(negedge clk);
      req_v = '0;
      #1 push_exp(-1);
   endtask

`ifdef CDB_ARB_STATS_EN
   task automatic test_stats();
      logic [N-1:0] ord [4] = '{3'b001, 3'b010, 3'b001, 3'b010};
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         set_unit(0, RW'(c), 6'd1, 2'b00, XLEN'(c), 1'b1);
         set_unit(1, RW'(c + 8), 6'd2, 2'b01, XLEN'(c + 100), 1'b1);
         req_v = 3'b011;
         #1;
         n_tests++;
         if (req_ready !== ord[c]) begin n_fail++; $display("FAIL stats_ready[%0d]: got %b want %b", c, req_ready, ord[c]); end
         push_exp(ord[c] == 3'b001 ? 0 : 1);
      end
      @(negedge clk);
      req_v = '0;
      #1;
      n_tests++;
      if (stall_cnt !== {16'd0, 16'd2, 16'd2}) begin
         n_fail++; $display("FAIL stall_cnt: got %h want %h", stall_cnt, {16'd0, 16'd2, 16'd2});
      end
      push_exp(-1);
   endtask
`endif

   initial begin
      req_v   = '0;
      req_w_v = '0;
      flush   = 1'b0;
      rst_n   = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_no_wb();
      test_flush();
      test_reset_midstream();
      test_back_to_back();
`ifdef CDB_ARB_STATS_EN
      test_stats();
`endif
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
